mips_cpu_mult: RTL and testbench
================================

# mips_cpu_mult

Sequential 32×32→64 shift-add multiplier with a signed/unsigned select. It is the multiply counterpart of the divider in the HI/LO unit and serves MULT and MULTU. It uses the same start/done handshake as the divider, so the HI/LO control logic drives both units the same way. The product is presented as `hi`/`lo` halves for direct write into the HI and LO registers.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start
- multiplicand  input  32  operand A; sampled with start
- multiplier  input  32  operand B; sampled with start
- hi  output  32  product[63:32]; registered
- lo  output  32  product[31:0]; registered
- done  output  1  one-cycle pulse when hi/lo become valid
- busy  output  1  high while in BUSY

## Operation
States:
- IDLE: after reset; waits for start.
- BUSY: iterates the shift-add.
- DONE: held for exactly one cycle, then IDLE.

Transitions:
- IDLE or DONE with start=1 → BUSY.
- BUSY exit condition met → DONE.
- DONE with start=0 → IDLE.

Accept edge (start=1 in IDLE or DONE):
- Latch `a_mag` (64-bit, zero-extended), `b_mag` (32-bit), `neg` and iteration count=0.
- Signed: magnitudes are the two's-complement absolute values. -2^31 maps to 0x80000000, taken as unsigned. `neg` = multiplicand[31] XOR multiplier[31].
- Unsigned: magnitudes are the raw operands and `neg`=0.
- Clear the 64-bit accumulator.

Per BUSY edge, non-exit:
- If b_mag[0]=1, accumulator += a_mag.
- a_mag <<= 1; b_mag >>= 1; count += 1.

Exit edge:
- Occurs in BUSY when count = 32.
- Writes {hi,lo} = neg ? -accumulator : accumulator, in 64-bit two's complement.
- Enters DONE.

Output behaviour:
- hi/lo keep their value from the last completion until the next exit edge. They do not change during BUSY.
- start during BUSY is ignored; operands are not re-sampled.
- start in DONE is accepted, giving back-to-back operations with no IDLE cycle.
- No overflow or exception outputs; every 32×32 product fits in 64 bits.

## Timing
- Reset (synchronous, highest priority, any state including mid-BUSY):
  - State returns to IDLE.
  - hi=0, lo=0, done=0, busy=0.
  - Accumulator, magnitudes and count are cleared.
  - The in-flight operation is discarded and no done is produced.
- Latency, default: the accept edge is E0. Edges E1..E32 iterate, E33 is the exit edge. done=1 and hi/lo are valid in the cycle after E33.
- done is high for exactly one cycle. busy is high from the cycle after E0 through the cycle containing E33.
- Back-to-back: if start=1 in the DONE cycle, the next accept edge is the edge that ends DONE. Throughput is 34 cycles per operation.

## Configuration
Macro: MIPS_CPU_MULT_EARLY_EXIT_EN.

Defined:
- Any BUSY edge with b_mag = 0 is an exit edge; the result is unchanged.
- multiplier=0 gives exit at E1, so done is visible in the cycle after E1.
- Unsigned multiplier=1 exits at E2.
- Worst case stays 33 edges.
- busy falls accordingly. Callers must rely only on done, never on a cycle count.

Undefined:
- Exit occurs only at count = 32. Latency is always 33 edges.

## Test plan
- Signed -3 × 7: start, sign=1, 0xFFFFFFFD, 0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. done is a single pulse; without the macro it is visible in the cycle after E33.
- Unsigned max × max: sign=0, 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. The same operands with sign=1 → hi=0x00000000, lo=0x00000001.
- Signed boundary: 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000. 0x80000000 × 0x00000001 → hi=0xFFFFFFFF, lo=0x80000000.
- Busy/back-to-back:
  - Assert start with changed operands in the middle of BUSY → ignored; the first result is unaffected.
  - start=1 in the DONE cycle with 5 × 6 → second done with lo=30, hi=0. No IDLE cycle between the two operations.
- Reset mid-operation: assert reset at E10 of 0x12345678 × 0x9ABCDEF0 → next cycle hi=0, lo=0, busy=0. No done follows. A new start then completes normally.
- Early exit (macro defined): 0x1234 × 0 → done in the cycle after E1, hi=lo=0. 0x1234 × 1 unsigned → done after E2, lo=0x1234. Without the macro, both take 33 edges.

Source files
------------

// File: rtl/mips_cpu_mult.sv
// rtl/mips_cpu_mult.sv - sequential 32x32->64 shift-add multiplier for MULT/MULTU
// Optional feature: MIPS_CPU_MULT_EARLY_EXIT_EN ends iteration as soon as the
// remaining multiplier magnitude is zero (latency becomes data dependent).
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         request, accepted only in IDLE or DONE
//   sign          1 = signed (MULT), 0 = unsigned (MULTU), sampled with start
//   multiplicand  operand A, sampled with start
//   multiplier    operand B, sampled with start
//   hi, lo        registered product[63:32] / product[31:0]
//   done          one-cycle pulse when hi/lo become valid
//   busy          high while iterating
module mips_cpu_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] a_mag;
  logic [63:0] acc;
  logic [31:0] b_mag;
  logic        neg;
  logic [5:0]  count;

  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        exit_now;
  logic [63:0] result;

  always_comb begin
    // Magnitudes of the operands; -2^31 negates to itself and is then read
    // as the unsigned value 0x80000000, which is exactly its magnitude.
    a_abs = (sign && multiplicand[31]) ? (~multiplicand + 32'd1) : multiplicand;
    b_abs = (sign && multiplier[31])   ? (~multiplier + 32'd1)   : multiplier;
`ifdef MIPS_CPU_MULT_EARLY_EXIT_EN
    // Once no multiplier bits remain, further iterations cannot change acc.
    exit_now = (count == 6'd32) || (b_mag == 32'd0);
`else
    exit_now = (count == 6'd32);
`endif
    result = neg ? (~acc + 64'd1) : acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_mag <= 64'd0;
      b_mag <= 32'd0;
      acc   <= 64'd0;
      neg   <= 1'b0;
      count <= 6'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_BUSY;
            busy  <= 1'b1;
            a_mag <= {32'd0, a_abs};
            b_mag <= b_abs;
            neg   <= sign & (multiplicand[31] ^ multiplier[31]);
            count <= 6'd0;
            acc   <= 64'd0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (exit_now) begin
            {hi, lo} <= result;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end else begin
            if (b_mag[0]) begin
              acc <= acc + a_mag;
            end
            a_mag <= a_mag << 1;
            b_mag <= b_mag >> 1;
            count <= count + 6'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mult.sv
// tb/tb_mips_cpu_mult.sv - self-checking bench for mips_cpu_mult
module tb_mips_cpu_mult;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sign;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef MIPS_CPU_MULT_EARLY_EXIT_EN
  localparam int L_B7   = 5;
  localparam int L_B6   = 5;
  localparam int L_B0   = 2;
  localparam int L_B1   = 3;
`else
  localparam int L_B7   = 34;
  localparam int L_B6   = 34;
  localparam int L_B0   = 34;
  localparam int L_B1   = 34;
`endif
  localparam int L_FULL = 34;

  mips_cpu_mult dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sign         (sign),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .hi           (hi),
    .lo           (lo),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full 64-bit product of the (optionally sign-extended) operands.
  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{s & a[31]}}, a};
    bx = {{32{s & b[31]}}, b};
    return ax * bx;
  endfunction

  // Reference: number of clock edges after the accept edge until the exit edge.
`ifdef MIPS_CPU_MULT_EARLY_EXIT_EN
  function automatic int ref_edges(input logic s, input logic [31:0] b);
    logic [31:0] m;
    int          top;
    m   = (s && b[31]) ? -b : b;
    top = 0;
    for (int i = 0; i < 32; i++) if (m[i]) top = i + 1;
    return (m == 32'd0) ? 1 : top + 1;
  endfunction
`else
  function automatic int ref_edges(input logic s, input logic [31:0] b);
    return (s | ~s) ? 33 : 33;
  endfunction
`endif

  // Behavioural model: an operation is either pending (edges remaining) or not.
  logic        m_valid = 1'b0;
  logic        m_busy;
  logic        m_done;
  logic [63:0] m_res;
  logic [63:0] m_prod;
  int          m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_res  = 64'd0;
      m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_prod;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1;
        m_left = ref_edges(sign, multiplier);
        m_prod = ref_prod(sign, multiplicand, multiplier);
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("done", {63'd0, done}, {63'd0, m_done});
      check("busy", {63'd0, busy}, {63'd0, m_busy});
      check("hilo", {hi, lo}, m_res);
    end
  end

  task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    start        = 1'b1;
    sign         = s;
    multiplicand = a;
    multiplier   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after do_start; returns negedges counted until done is seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] lit, input int lit_cyc);
    int cyc;
    do_start(s, a, b);
    wait_done(cyc);
    check({name, "_hilo"}, {hi, lo}, lit);
    if (lit_cyc != 0) check({name, "_latency"}, 64'(cyc), 64'(lit_cyc));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          cyc;
    logic        seen;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;

    reset        = 1'b1;
    start        = 1'b0;
    sign         = 1'b0;
    multiplicand = 32'd0;
    multiplier   = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, done, busy}, 64'd0);
    @(negedge clk);

    // Hand-computed products pin the reference model.
    run_op("neg3x7", 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, L_B7);
    // Back-to-back: start in the DONE cycle, no IDLE gap.
    do_start(1'b0, 32'd5, 32'd6);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done(cyc);
    check("b2b_hilo", {hi, lo}, 64'd30);
    check("b2b_latency", 64'(cyc), 64'(L_B6));
    @(negedge clk);

    run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, L_FULL);
    run_op("smax", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, L_B1);
    run_op("minsq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, L_FULL);
    run_op("minx1", 1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, L_B1);
    run_op("early0", 1'b0, 32'h0000_1234, 32'h0000_0000, 64'd0, L_B0);
    run_op("early1", 1'b0, 32'h0000_1234, 32'h0000_0001, 64'h0000_0000_0000_1234, L_B1);
    @(negedge clk);

    // start during BUSY with other operands must be ignored.
    do_start(1'b1, 32'h8000_0000, 32'h8000_0000);
    repeat (5) @(negedge clk);
    do_start(1'b0, 32'h0000_0003, 32'h0000_0003);
    wait_done(cyc);
    check("midbusy_hilo", {hi, lo}, 64'h4000_0000_0000_0000);
    @(negedge clk);

    // Reset sampled at E10 discards the operation.
    do_start(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_flags", {62'd0, done, busy}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("midreset_nodone", {63'd0, seen}, 64'd0);
    run_op("after_reset", 1'b0, 32'd5, 32'd6, 64'd30, L_B6);

    // Randomized operations, sometimes back-to-back, checked by the model.
    for (int i = 0; i < 40; i++) begin
      s = 1'(($urandom & 1));
      a = pick();
      b = pick();
      do_start(s, a, b);
      wait_done(cyc);
      check("rand_latency", 64'(cyc), 64'(ref_edges(s, b) + 1));
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
